// File: rtl/pg_port_isolator_if.sv
// AXI-S bundle between the PF/VF MUX (mx_*) and the port AFUs (afu_*), one lane per port.
// master = MUX/AFU environment side, slave = pg_port_isolator.
interface pg_port_isolator_if #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 512,
    parameter int USER_W    = 10
);
    logic [NUM_PORTS-1:0]        mx_rx_tvalid;
    logic [NUM_PORTS-1:0]        mx_rx_tlast;
    logic [NUM_PORTS*DATA_W-1:0] mx_rx_tdata;
    logic [NUM_PORTS*USER_W-1:0] mx_rx_tuser;
    logic [NUM_PORTS-1:0]        mx_rx_tready;

    logic [NUM_PORTS-1:0]        afu_rx_tvalid;
    logic [NUM_PORTS-1:0]        afu_rx_tlast;
    logic [NUM_PORTS*DATA_W-1:0] afu_rx_tdata;
    logic [NUM_PORTS*USER_W-1:0] afu_rx_tuser;
    logic [NUM_PORTS-1:0]        afu_rx_tready;

    logic [NUM_PORTS-1:0]        afu_tx_tvalid;
    logic [NUM_PORTS-1:0]        afu_tx_tlast;
    logic [NUM_PORTS*DATA_W-1:0] afu_tx_tdata;
    logic [NUM_PORTS*USER_W-1:0] afu_tx_tuser;
    logic [NUM_PORTS-1:0]        afu_tx_tready;

    logic [NUM_PORTS-1:0]        mx_tx_tvalid;
    logic [NUM_PORTS-1:0]        mx_tx_tlast;
    logic [NUM_PORTS*DATA_W-1:0] mx_tx_tdata;
    logic [NUM_PORTS*USER_W-1:0] mx_tx_tuser;
    logic [NUM_PORTS-1:0]        mx_tx_tready;

    modport master (
        output mx_rx_tvalid, mx_rx_tlast, mx_rx_tdata, mx_rx_tuser, input mx_rx_tready,
        input  afu_rx_tvalid, afu_rx_tlast, afu_rx_tdata, afu_rx_tuser, output afu_rx_tready,
        output afu_tx_tvalid, afu_tx_tlast, afu_tx_tdata, afu_tx_tuser, input afu_tx_tready,
        input  mx_tx_tvalid, mx_tx_tlast, mx_tx_tdata, mx_tx_tuser, output mx_tx_tready
    );

    modport slave (
        input  mx_rx_tvalid, mx_rx_tlast, mx_rx_tdata, mx_rx_tuser, output mx_rx_tready,
        output afu_rx_tvalid, afu_rx_tlast, afu_rx_tdata, afu_rx_tuser, input afu_rx_tready,
        input  afu_tx_tvalid, afu_tx_tlast, afu_tx_tdata, afu_tx_tuser, output afu_tx_tready,
        output mx_tx_tvalid, mx_tx_tlast, mx_tx_tdata, mx_tx_tuser, input mx_tx_tready
    );
endinterface

// File: rtl/pg_port_isolator.sv
// Packet-aware per-port reset sequencer: RUN -> DRAIN -> ISOLATED -> RELEASE -> RUN.
// Define PG_ISO_DROP_CNT_EN to build the per-port dropped-RX-packet counters.
module pg_port_isolator #(
    parameter int NUM_PORTS     = 2,
    parameter int DATA_W        = 512,
    parameter int USER_W        = 10,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int RST_HOLD      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PORTS-1:0]    port_rst_n_in,
    output logic [NUM_PORTS-1:0]    port_rst_n_out,
    output logic [NUM_PORTS-1:0]    trunc_err,
    output logic [NUM_PORTS*16-1:0] drop_cnt,
    pg_port_isolator_if.slave       bus
);
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_ISOLATED, ST_RELEASE} state_t;

    localparam int DCW = $clog2(DRAIN_TIMEOUT + 1);
    localparam int HCW = $clog2(RST_HOLD + 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_TIMEOUT - 1);
    localparam logic [HCW-1:0] HOLD_LAST  = HCW'(RST_HOLD - 1);

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        state_t         state_reg, state_next;
        logic [DCW-1:0] drain_cnt_reg, drain_cnt_next;
        logic [HCW-1:0] hold_cnt_reg, hold_cnt_next;
        logic           rx_mid_reg, rx_mid_next;
        logic           tx_mid_reg, tx_mid_next;
        logic           trunc_reg, rst_n_reg;
        logic           rx_sink, tx_pass, term;
        logic           mx_rx_rdy, mx_tx_vld, mx_tx_lst, rx_acc, tx_acc;

        // Outside RUN every RX beat is swallowed; TX only finishes a packet already started.
        assign rx_sink = (state_reg != ST_RUN);
        assign term    = (state_reg == ST_DRAIN) && tx_mid_reg && (drain_cnt_reg == DRAIN_LAST);
        assign tx_pass = (state_reg == ST_RUN) || ((state_reg == ST_DRAIN) && tx_mid_reg && !term);

        assign bus.afu_rx_tvalid[gi] = bus.mx_rx_tvalid[gi] & ~rx_sink;
        assign bus.afu_rx_tlast[gi]  = bus.mx_rx_tlast[gi];
        assign bus.afu_rx_tdata[gi*DATA_W +: DATA_W] = bus.mx_rx_tdata[gi*DATA_W +: DATA_W];
        assign bus.afu_rx_tuser[gi*USER_W +: USER_W] = bus.mx_rx_tuser[gi*USER_W +: USER_W];
        assign mx_rx_rdy             = rx_sink | bus.afu_rx_tready[gi];
        assign bus.mx_rx_tready[gi]  = mx_rx_rdy;

        // The synthesized terminator is a zero beat with tlast, held until the MUX takes it.
        assign mx_tx_vld             = term | (tx_pass & bus.afu_tx_tvalid[gi]);
        assign mx_tx_lst             = term | bus.afu_tx_tlast[gi];
        assign bus.mx_tx_tvalid[gi]  = mx_tx_vld;
        assign bus.mx_tx_tlast[gi]   = mx_tx_lst;
        assign bus.mx_tx_tdata[gi*DATA_W +: DATA_W] = term ? '0 : bus.afu_tx_tdata[gi*DATA_W +: DATA_W];
        assign bus.mx_tx_tuser[gi*USER_W +: USER_W] = term ? '0 : bus.afu_tx_tuser[gi*USER_W +: USER_W];
        assign bus.afu_tx_tready[gi] = tx_pass & bus.mx_tx_tready[gi];

        assign rx_acc = bus.mx_rx_tvalid[gi] & mx_rx_rdy;
        assign tx_acc = mx_tx_vld & bus.mx_tx_tready[gi];

        always_comb begin
            state_next     = state_reg;
            drain_cnt_next = drain_cnt_reg;
            hold_cnt_next  = hold_cnt_reg;
            rx_mid_next    = rx_acc ? ~bus.mx_rx_tlast[gi] : rx_mid_reg;
            tx_mid_next    = tx_acc ? ~mx_tx_lst : tx_mid_reg;
            case (state_reg)
                ST_RUN: begin
                    if (!port_rst_n_in[gi]) begin
                        state_next     = ST_DRAIN;
                        drain_cnt_next = '0;
                    end
                end
                ST_DRAIN: begin
                    if (!tx_mid_next) begin
                        state_next    = ST_ISOLATED;
                        hold_cnt_next = '0;
                    end else if (drain_cnt_reg != DRAIN_LAST) begin
                        drain_cnt_next = drain_cnt_reg + 1'b1;
                    end
                end
                ST_ISOLATED: begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        if (port_rst_n_in[gi]) state_next = ST_RELEASE;
                    end else begin
                        hold_cnt_next = hold_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    // Re-request restarts the hold; otherwise wait for an RX packet boundary.
                    if (!port_rst_n_in[gi]) begin
                        state_next    = ST_ISOLATED;
                        hold_cnt_next = '0;
                    end else if (!rx_mid_reg && !rx_acc) begin
                        state_next = ST_RUN;
                    end
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_reg     <= ST_ISOLATED;
                drain_cnt_reg <= '0;
                hold_cnt_reg  <= '0;
                rx_mid_reg    <= 1'b0;
                tx_mid_reg    <= 1'b0;
                trunc_reg     <= 1'b0;
                rst_n_reg     <= 1'b0;
            end else begin
                state_reg     <= state_next;
                drain_cnt_reg <= drain_cnt_next;
                hold_cnt_reg  <= hold_cnt_next;
                rx_mid_reg    <= rx_mid_next;
                tx_mid_reg    <= tx_mid_next;
                trunc_reg     <= trunc_reg | term;
                rst_n_reg     <= (state_next != ST_ISOLATED);
            end
        end

        assign port_rst_n_out[gi] = rst_n_reg;
        assign trunc_err[gi]      = trunc_reg;

`ifdef PG_ISO_DROP_CNT_EN
        logic [15:0] drop_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                drop_reg <= '0;
            end else if ((state_reg == ST_ISOLATED) && (state_next == ST_RELEASE)) begin
                drop_reg <= '0;
            end else if (rx_sink && rx_acc && bus.mx_rx_tlast[gi] && (drop_reg != 16'hFFFF)) begin
                drop_reg <= drop_reg + 16'd1;
            end
        end
        assign drop_cnt[gi*16 +: 16] = drop_reg;
`else
        assign drop_cnt[gi*16 +: 16] = 16'd0;
`endif
    end
endmodule

// File: tb/tb_pg_port_isolator.sv
// Directed bench for pg_port_isolator: RUN pass-through table plus reset/drain/timeout/release sequences.
module tb_pg_port_isolator;
    localparam int NP = 2;
    localparam int DW = 32;
    localparam int UW = 10;
`ifdef PG_ISO_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP-1:0]   port_rst_n_in;
    logic [NP-1:0]   port_rst_n_out;
    logic [NP-1:0]   trunc_err;
    logic [NP*16-1:0] drop_cnt;
    int n_checks = 0;
    int n_fail   = 0;

    pg_port_isolator_if #(.NUM_PORTS(NP), .DATA_W(DW), .USER_W(UW)) bus ();

    pg_port_isolator #(
        .NUM_PORTS(NP), .DATA_W(DW), .USER_W(UW), .DRAIN_TIMEOUT(8), .RST_HOLD(16)
    ) dut (
        .clk(clk), .rst(rst), .port_rst_n_in(port_rst_n_in), .port_rst_n_out(port_rst_n_out),
        .trunc_err(trunc_err), .drop_cnt(drop_cnt), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rx_v; logic rx_l; logic [31:0] rx_d; logic afu_rdy;
        logic tx_v; logic tx_l; logic [31:0] tx_d; logic mx_rdy;
        logic e_afu_rx_v; logic e_mx_rx_rdy; logic e_mx_tx_v; logic e_afu_tx_rdy;
    } vec_t;
    vec_t vecs[8];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[%0t] FAIL %s: got %0h expected %0h", $time, name, got, exp);
        end else begin
            $display("[%0t] %s ok (%0h)", $time, name, got);
        end
    endtask

    task automatic rx0(input logic v, input logic l, input logic [31:0] d);
        bus.mx_rx_tvalid[0] = v;
        bus.mx_rx_tlast[0]  = l;
        bus.mx_rx_tdata[DW-1:0] = d;
        bus.mx_rx_tuser[UW-1:0] = d[UW-1:0];
    endtask

    task automatic tx0(input logic v, input logic l, input logic [31:0] d);
        bus.afu_tx_tvalid[0] = v;
        bus.afu_tx_tlast[0]  = l;
        bus.afu_tx_tdata[DW-1:0] = d;
        bus.afu_tx_tuser[UW-1:0] = d[UW-1:0];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit found;
        int lows;

        vecs[0] = '{1'b1, 1'b0, 32'hA0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 32'hA0, 1'b1, 1'b1, 1'b0, 32'hB0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'hA1, 1'b1, 1'b1, 1'b0, 32'hB0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 32'hA2, 1'b0, 1'b1, 1'b1, 32'hB1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 32'hA2, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 32'hA3, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        port_rst_n_in     = '1;
        bus.mx_rx_tvalid  = '0; bus.mx_rx_tlast = '0; bus.mx_rx_tdata = '0; bus.mx_rx_tuser = '0;
        bus.afu_rx_tready = '1;
        bus.afu_tx_tvalid = '0; bus.afu_tx_tlast = '0; bus.afu_tx_tdata = '0; bus.afu_tx_tuser = '0;
        bus.mx_tx_tready  = '1;

        // Reset state: both ports isolated, RX sunk, nothing valid.
        #2;
        check("reset_rst_out", 128'(port_rst_n_out), 128'(2'b00));
        check("reset_stream", 128'({bus.mx_rx_tready, bus.afu_rx_tvalid, bus.mx_tx_tvalid}), 128'(6'b110000));
        check("reset_status", 128'({trunc_err, drop_cnt}), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) tick();
        check("release_after_reset", 128'(port_rst_n_out), 128'(2'b11));

        // RUN pass-through, 0-cycle latency; port 1 stays idle.
        for (int i = 0; i < 8; i++) begin
            rx0(vecs[i].rx_v, vecs[i].rx_l, vecs[i].rx_d);
            bus.afu_rx_tready[0] = vecs[i].afu_rdy;
            tx0(vecs[i].tx_v, vecs[i].tx_l, vecs[i].tx_d);
            bus.mx_tx_tready[0] = vecs[i].mx_rdy;
            settle();
            check($sformatf("vec%0d_ctl", i),
                  128'({bus.afu_rx_tvalid[0], bus.mx_rx_tready[0], bus.mx_tx_tvalid[0], bus.afu_tx_tready[0],
                        bus.afu_rx_tlast[0], bus.mx_tx_tlast[0], bus.afu_rx_tvalid[1]}),
                  128'({vecs[i].e_afu_rx_v, vecs[i].e_mx_rx_rdy, vecs[i].e_mx_tx_v, vecs[i].e_afu_tx_rdy,
                        vecs[i].rx_l, vecs[i].tx_l, 1'b0}));
            check($sformatf("vec%0d_data", i),
                  128'({bus.afu_rx_tuser[UW-1:0], bus.afu_rx_tdata[DW-1:0], bus.mx_tx_tdata[DW-1:0]}),
                  128'({vecs[i].rx_d[UW-1:0], vecs[i].rx_d, vecs[i].tx_d}));
            tick();
        end

        // Idle port reset: DRAIN one cycle, then 16 cycles of port reset.
        bus.afu_rx_tready[0] = 1'b0;
        bus.mx_tx_tready[0]  = 1'b1;
        port_rst_n_in[0] = 1'b0;
        tick();
        port_rst_n_in[0] = 1'b1;
        settle();
        check("idle_drain", 128'({port_rst_n_out[0], bus.mx_rx_tready[0], bus.mx_tx_tvalid[0], bus.afu_tx_tready[0]}),
              128'(4'b1100));
        lows = 0;
        for (int c = 0; c < 30; c++) begin
            settle();
            if (!port_rst_n_out[0]) lows++;
        end
        check("idle_rst_len", 128'(lows), 128'(16));
        check("idle_back_run", 128'({port_rst_n_out[0], bus.mx_rx_tready[0]}), 128'(2'b10));
        tick();
        bus.afu_rx_tready[0] = 1'b1;

        // Reset during beat 2 of a 5-beat TX packet: remaining beats still delivered.
        for (int b = 0; b < 5; b++) begin
            tx0(1'b1, 1'(b == 4), 32'(32'hC0 + b));
            port_rst_n_in[0] = (b == 2) ? 1'b0 : 1'b1;
            settle();
            if (b >= 3)
                check($sformatf("drain_tx_beat%0d", b),
                      128'({port_rst_n_out[0], bus.mx_tx_tvalid[0], bus.afu_tx_tready[0], bus.mx_tx_tlast[0],
                            bus.mx_tx_tdata[DW-1:0]}),
                      128'({1'b1, 1'b1, 1'b1, 1'(b == 4), 32'(32'hC0 + b)}));
            tick();
        end
        tx0(1'b0, 1'b0, 32'h0);
        settle();
        check("drain_exit", 128'({port_rst_n_out[0], trunc_err[0]}), 128'(2'b00));
        repeat (25) tick();

        // AFU stalls mid-packet: terminator on the 8th DRAIN cycle.
        tx0(1'b1, 1'b0, 32'hD0);
        bus.mx_tx_tready[0] = 1'b1;
        port_rst_n_in[0] = 1'b0;
        tick();
        tx0(1'b0, 1'b0, 32'h0);
        port_rst_n_in[0] = 1'b1;
        bus.mx_tx_tready[0] = 1'b0;
        k = 0;
        found = 1'b0;
        while (k < 20 && !found) begin
            settle();
            if (bus.mx_tx_tvalid[0]) found = 1'b1;
            else k++;
        end
        check("term_cycle", 128'(k), 128'(7));
        check("term_beat", 128'({bus.mx_tx_tlast[0], bus.mx_tx_tdata[DW-1:0], bus.mx_tx_tuser[UW-1:0], bus.afu_tx_tready[0]}),
              128'({1'b1, 32'h0, 10'h0, 1'b0}));
        settle();
        check("term_hold", 128'({bus.mx_tx_tvalid[0], bus.mx_tx_tlast[0], bus.mx_tx_tdata[DW-1:0], trunc_err[0], port_rst_n_out[0]}),
              128'({1'b1, 1'b1, 32'h0, 1'b1, 1'b1}));
        @(posedge clk); #1;
        bus.mx_tx_tready[0] = 1'b1;
        tick();
        settle();
        check("term_isolated", 128'({port_rst_n_out[0], bus.mx_tx_tvalid[0], trunc_err[0]}), 128'(3'b001));
        repeat (25) tick();

        // Three 3-beat RX packets while isolated are sunk and counted.
        port_rst_n_in[0] = 1'b0;
        bus.afu_rx_tready[0] = 1'b0;
        repeat (3) tick();
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 3; b++) begin
                rx0(1'b1, 1'(b == 2), 32'(32'hE0 + p * 4 + b));
                settle();
                check($sformatf("sink_p%0d_b%0d", p, b), 128'({bus.mx_rx_tready[0], bus.afu_rx_tvalid[0]}), 128'(2'b10));
                tick();
            end
        end
        rx0(1'b0, 1'b0, 32'h0);
        settle();
        check("drop_cnt_iso", 128'(drop_cnt), 128'({16'h0, DROP_EN ? 16'd3 : 16'd0}));
        tick();

        // Release with an RX packet mid-flight: wait for its tlast, then deliver the next one whole.
        rx0(1'b1, 1'b0, 32'hF00);
        tick();
        rx0(1'b0, 1'b0, 32'h0);
        port_rst_n_in[0] = 1'b1;
        repeat (8) tick();
        settle();
        check("release_wait", 128'({port_rst_n_out[0], bus.mx_rx_tready[0], drop_cnt[15:0]}), 128'({1'b1, 1'b1, 16'h0}));
        tick();
        rx0(1'b1, 1'b1, 32'hF01);
        settle();
        check("release_tail", 128'({bus.afu_rx_tvalid[0], bus.mx_rx_tready[0]}), 128'(2'b01));
        tick();
        rx0(1'b0, 1'b0, 32'h0);
        settle();
        check("release_idle", 128'({bus.mx_rx_tready[0], drop_cnt[15:0]}), 128'({1'b1, DROP_EN ? 16'd1 : 16'd0}));
        tick();
        settle();
        check("release_to_run", 128'(bus.mx_rx_tready[0]), 128'(1'b0));
        tick();
        bus.afu_rx_tready[0] = 1'b1;
        for (int b = 0; b < 2; b++) begin
            rx0(1'b1, 1'(b == 1), 32'(32'hF10 + b));
            settle();
            check($sformatf("run_pkt_b%0d", b),
                  128'({bus.afu_rx_tvalid[0], bus.afu_rx_tlast[0], bus.mx_rx_tready[0], bus.afu_rx_tdata[DW-1:0]}),
                  128'({1'b1, 1'(b == 1), 1'b1, 32'(32'hF10 + b)}));
            tick();
        end
        rx0(1'b0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pg_port_isolator.md
# pg_port_isolator

Per-port traffic isolation and reset sequencer between the port-gasket PF/VF MUX AFU-side outputs and the port AFU instances. For each of NUM_PORTS linearised ports it passes RX/TX AXI-S traffic through unmodified while the port is up. When a port reset is requested, it quiesces that port at packet boundaries, sinks host traffic addressed to it, and only then drives the AFU-side port reset. This generalises the fixed two-flop port reset pipeline into a configurable, packet-aware sequencer.

## Interface
- NUM_PORTS, 2: number of linearised ports (links × ports per link).
- DATA_W, 512: tdata width per port.
- USER_W, 10: tuser width per port.
- DRAIN_TIMEOUT, 1024: maximum cycles DRAIN waits for the AFU to finish an in-flight TX packet; must be ≥ 1.
- RST_HOLD, 16: minimum cycles port_rst_n_out is held low; must be ≥ 1.
- clk  in  1  sole clock; all inputs are synchronous to it.
- rst  in  1  asynchronous, active-high reset.
- port_rst_n_in  in  NUM_PORTS  per-port reset request from the FME, active-low.
- port_rst_n_out  out  NUM_PORTS  registered per-port reset to the AFU, active-low.
- mx_rx_tvalid/tlast  in  NUM_PORTS each; mx_rx_tdata  in  NUM_PORTS*DATA_W; mx_rx_tuser  in  NUM_PORTS*USER_W: RX stream from the MUX.
- mx_rx_tready  out  NUM_PORTS.
- afu_rx_tvalid/tlast/tdata/tuser  out  (widths as for mx_rx); afu_rx_tready  in  NUM_PORTS: RX stream to the AFU.
- afu_tx_tvalid/tlast/tdata/tuser  in; afu_tx_tready  out: TX stream from the AFU.
- mx_tx_tvalid/tlast/tdata/tuser  out; mx_tx_tready  in: TX stream to the MUX.
- trunc_err  out  NUM_PORTS  sticky; set when a TX packet was force-terminated.
- drop_cnt  out  NUM_PORTS*16  per-port dropped RX packet counts; see Configuration.

## Operation
- Each port runs an independent 4-state FSM: RUN, DRAIN, ISOLATED, RELEASE.
- Each port keeps two mid-packet flags, rx_mid and tx_mid.
  - A flag sets on an accepted beat with tlast=0.
  - A flag clears on an accepted beat with tlast=1.
  - A beat is accepted when tvalid && tready on the MUX side.
- RUN:
  - RX and TX pass through combinationally, with tready fed back.
  - port_rst_n_in=0 → DRAIN.
- DRAIN:
  - RX: mx_rx_tready=1 and afu_rx_tvalid=0, so all RX beats are sunk.
    - The first sunk packet, if rx_mid was set, is a truncation of a packet the AFU already saw.
  - TX: passes through only while tx_mid=1. If tx_mid=0, afu_tx_tready=0 and mx_tx_tvalid=0.
  - Timeout counter counts from 0 each cycle.
  - Exit DRAIN → ISOLATED when tx_mid=0 (that cycle's accept included).
  - On reaching DRAIN_TIMEOUT-1 with tx_mid=1, the block drives one beat to the MUX with tvalid=1, tlast=1, tdata=0, tuser=0, and sets trunc_err.
    - AFU tready=0 during this beat.
    - On its acceptance → ISOLATED.
- ISOLATED:
  - port_rst_n_out=0.
  - RX is sunk (mx_rx_tready=1). TX is blocked (afu_tx_tready=0, mx_tx_tvalid=0).
  - Hold counter counts from 0.
  - → RELEASE when the hold counter has reached RST_HOLD-1 and port_rst_n_in=1.
- RELEASE:
  - port_rst_n_out=1. RX is still sunk, TX still blocked.
  - → RUN on the first cycle with rx_mid=0 and no RX beat being accepted.
    - This guarantees the AFU sees RX only from a packet start.
- RX packets sunk in DRAIN, ISOLATED and RELEASE count once each, at tlast acceptance.
- trunc_err clears only on rst.
- port_rst_n_in asserted again during RELEASE → ISOLATED, with the hold counter restarted.
- port_rst_n_in deasserting during DRAIN does not abort DRAIN.
- All counters saturate and never wrap.

## Timing
- Reset values:
  - All FSMs: ISOLATED, with the hold counter at 0.
  - port_rst_n_out=0.
  - rx_mid/tx_mid=0, trunc_err=0, drop_cnt=0.
  - Streaming outputs follow the ISOLATED rules: mx_rx_tready=1, all tvalid=0.
- Data path latency is 0 cycles in RUN.
- State transitions and port_rst_n_out are registered: they change the cycle after the condition is met.
- Minimum port reset sequence with an idle port:
  - RUN → DRAIN: cycle 1.
  - → ISOLATED: cycle 2.
  - port_rst_n_out=0: cycles 2 through 2+RST_HOLD-1.
- rst asserted mid-packet forces ISOLATED immediately and asynchronously, and discards the mid-packet flags.
- tvalid never depends on tready.
- Data, tlast and tuser are held stable while tvalid=1 and tready=0, including the synthesized terminator beat.

## Configuration
- PG_ISO_DROP_CNT_EN defined:
  - drop_cnt implements 16-bit saturating counters per port.
  - A counter clears on the rising edge of that port's port_rst_n_out.
- Not defined:
  - drop_cnt is tied to 0.
  - No counter logic is generated.

## Test plan
- NUM_PORTS=2, port 0 in RUN, 4-beat RX packet with afu_rx_tready toggling → identical beats on port 0 AFU side, 0-cycle latency; port 1 unaffected.
- Port 0 reset with an idle port → DRAIN 1 cycle, then port_rst_n_out[0]=0 for exactly 16 cycles after port_rst_n_in rises.
- Reset while the AFU is on beat 2 of a 5-beat TX packet, remaining beats delivered → ISOLATED after tlast accept, trunc_err[0]=0.
- DRAIN_TIMEOUT=8, AFU stalls mid-TX packet → one zero beat with tlast=1 at cycle 8, trunc_err[0]=1, then ISOLATED.
- Three 3-beat RX packets arrive while isolated → all sunk with tready=1, drop_cnt[0]=3 with PG_ISO_DROP_CNT_EN defined, 0 without.
- Release while an upstream RX packet is mid-flight → stays in RELEASE until its tlast; the next packet is delivered whole.
